// File: rtl/score_display_if.sv
// Request/handshake and display bus between gameplay requesters and the
// shared score/combo display sequencer.
interface score_display_if #(
    parameter int unsigned SCORE_W = 14,
    parameter int unsigned COMBO_W = 7
);
    logic               score_valid;
    logic [SCORE_W-1:0] score_data;
    logic               score_ready;
    logic               combo_valid;
    logic [COMBO_W-1:0] combo_data;
    logic               combo_ready;
    logic [23:0]        hex_codes;
    logic               busy;

    modport slave (
        input  score_valid,
        input  score_data,
        input  combo_valid,
        input  combo_data,
        output score_ready,
        output combo_ready,
        output hex_codes,
        output busy
    );

    modport master (
        output score_valid,
        output score_data,
        output combo_valid,
        output combo_data,
        input  score_ready,
        input  combo_ready,
        input  hex_codes,
        input  busy
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Shares one serial binary-to-BCD converter between score and combo requests
// and holds leading-zero-blanked digit codes for the six HEX decoders.
module score_display_ctrl #(
    parameter int unsigned SCORE_W = 14,
    parameter int unsigned COMBO_W = 7
) (
    input  logic            clk,
    input  logic            resetn,
    score_display_if.slave  bus
);

    localparam int unsigned BIN_W   = 14;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned HEX_W   = 24;
    localparam int unsigned SCORE_MAX = 9999;
    localparam int unsigned COMBO_MAX = 99;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [3:0]       BLANK     = 4'hE;
    localparam logic [HEX_W-1:0] HEX_RESET = 24'hE0EEE0;

    logic [1:0]       state_q,       state_d;
    logic             grant_score_q, grant_score_d;
    logic             last_score_q,  last_score_d;
    logic [BIN_W-1:0] bin_q,         bin_d;
    logic [BCD_W-1:0] bcd_q,         bcd_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [HEX_W-1:0] disp_q,        disp_d;
    logic [HEX_W-1:0] hex_q,         hex_d;

    logic               idle_c;
    logic               grant_score_c;
    logic               grant_combo_c;
    logic [SCORE_W-1:0] score_clamp_c;
    logic [COMBO_W-1:0] combo_clamp_c;
    logic [BCD_W-1:0]   bcd_adj_c;
    logic [BCD_W+BIN_W-1:0] shift_c;
    logic [15:0]        score_field_c;
    logic [7:0]         combo_field_c;

    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        idle_c        = (state_q == S_IDLE);
        grant_score_c = bus.score_valid & (~bus.combo_valid | ~last_score_q);
        grant_combo_c = bus.combo_valid & ~grant_score_c;
    end

    assign bus.score_ready = idle_c & grant_score_c;
    assign bus.combo_ready = idle_c & grant_combo_c;
    assign bus.busy        = ~idle_c;
    assign bus.hex_codes   = hex_q;

    // Saturate requests to what the display fields can show.
    always_comb begin
        score_clamp_c = bus.score_data;
        combo_clamp_c = bus.combo_data;
        if (bus.score_data > SCORE_W'(SCORE_MAX)) begin
            score_clamp_c = SCORE_W'(SCORE_MAX);
        end
        if (bus.combo_data > COMBO_W'(COMBO_MAX)) begin
            combo_clamp_c = COMBO_W'(COMBO_MAX);
        end
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin}.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_c = {bcd_adj_c, bin_q} << 1;
    end

    // Leading-zero blanking; the units digit is always shown.
    always_comb begin
        score_field_c = bcd_q;
        combo_field_c = bcd_q[7:0];
        if (bcd_q[15:12] == 4'd0) begin
            score_field_c[15:12] = BLANK;
            if (bcd_q[11:8] == 4'd0) begin
                score_field_c[11:8] = BLANK;
                if (bcd_q[7:4] == 4'd0) begin
                    score_field_c[7:4] = BLANK;
                end
            end
        end
        if (bcd_q[7:4] == 4'd0) begin
            combo_field_c[7:4] = BLANK;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        grant_score_d = grant_score_q;
        last_score_d  = last_score_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        disp_d        = disp_q;
        hex_d         = disp_q;

        case (state_q)
            S_IDLE: begin
                if (grant_score_c | grant_combo_c) begin
                    grant_score_d = grant_score_c;
                    last_score_d  = grant_score_c;
                    bin_d         = grant_score_c ? BIN_W'(score_clamp_c)
                                                  : BIN_W'(combo_clamp_c);
                    bcd_d         = '0;
                    cnt_d         = '0;
                    state_d       = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = shift_c[BCD_W+BIN_W-1:BIN_W];
                bin_d = shift_c[BIN_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (grant_score_q) begin
                    disp_d[15:0] = score_field_c;
                end else begin
                    disp_d[23:16] = combo_field_c;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            grant_score_q <= 1'b0;
            last_score_q  <= 1'b0;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            disp_q        <= HEX_RESET;
            hex_q         <= HEX_RESET;
        end else begin
            state_q       <= state_d;
            grant_score_q <= grant_score_d;
            last_score_q  <= last_score_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            disp_q        <= disp_d;
            hex_q         <= hex_d;
        end
    end

endmodule
